de_stage_register: RTL and testbench

Parametrised decode/execute stage register for the five-stage pipeline. It carries control signals, destination register number, N source register numbers and an address field. Beyond plain capture, it adds a valid bit, downstream stall (hold), branch flush (bubble) and built-in load-use hazard detection that inserts one bubble and stalls upstream. A saturating counter reports how many hazard bubbles were inserted, for performance debug.

---
 rtl/de_pkg.sv | 19 +
 rtl/de_load_use_detect.sv | 28 ++
 rtl/de_stage_register.sv | 103 ++++++++++
 tb/tb_de_stage_register.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/de_pkg.sv
// Shared widths and stage payload type for the decode/execute stage register.
// Constants only; no logic, no latency.
package de_pkg;
    localparam int DE_CTRL_W       = 14;
    localparam int DE_DST_W        = 3;
    localparam int DE_SRC_W        = 4;
    localparam int DE_NUM_SRC      = 2;
    localparam int DE_ADDR_W       = 16;
    localparam int DE_MEM_READ_BIT = 0;
    localparam int DE_CNT_W        = 16;

    typedef struct packed {
        logic [DE_CTRL_W-1:0]            ctrl;
        logic [DE_DST_W-1:0]             dst;
        logic [DE_NUM_SRC*DE_SRC_W-1:0]  src;
        logic [DE_ADDR_W-1:0]            addr;
        logic                            valid;
    } de_payload_t;
endpackage

// File: rtl/de_load_use_detect.sv
// Load-use hazard compare: a valid load in the stage feeds a source of the incoming instruction.
// Purely combinational, zero latency; no flow control of its own.
module de_load_use_detect #(
    parameter int DST_W   = 3,
    parameter int SRC_W   = 4,
    parameter int NUM_SRC = 2
) (
    input  logic                     stage_vld,
    input  logic                     stage_is_load,
    input  logic [DST_W-1:0]         stage_dst,
    input  logic                     in_vld,
    input  logic [NUM_SRC*SRC_W-1:0] in_src,
    output logic                     hazard
);
    logic src_match;

    // Full-width compare against the zero-extended destination, so any upper source bit blocks a match.
    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_src[i*SRC_W +: SRC_W] == SRC_W'(stage_dst)) begin
                src_match = 1'b1;
            end
        end
    end

    assign hazard = stage_vld & stage_is_load & in_vld & src_match;
endmodule

// File: rtl/de_stage_register.sv
// Decode/execute pipeline register with flush, hold, load-use bubble insertion and bubble counter.
// Latency 1 cycle; stall_in holds everything, a hazard inserts one bubble and raises hazard_stall_out.
module de_stage_register
    import de_pkg::*;
#(
    parameter int CTRL_W       = DE_CTRL_W,
    parameter int DST_W        = DE_DST_W,
    parameter int SRC_W        = DE_SRC_W,
    parameter int NUM_SRC      = DE_NUM_SRC,
    parameter int ADDR_W       = DE_ADDR_W,
    parameter int MEM_READ_BIT = DE_MEM_READ_BIT,
    parameter int CNT_W        = DE_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic [DST_W-1:0]         dst_in,
    input  logic [NUM_SRC*SRC_W-1:0] src_in,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic                     valid_in,
    input  logic                     stall_in,
    input  logic                     flush_in,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic [DST_W-1:0]         dst_out,
    output logic [NUM_SRC*SRC_W-1:0] src_out,
    output logic [ADDR_W-1:0]        addr_out,
    output logic                     valid_out,
    output logic                     hazard_stall_out,
    output logic [CNT_W-1:0]         bubble_count_out
);
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [DST_W-1:0]         dst_q, dst_d;
    logic [NUM_SRC*SRC_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     hazard;

    de_load_use_detect #(
        .DST_W   (DST_W),
        .SRC_W   (SRC_W),
        .NUM_SRC (NUM_SRC)
    ) u_detect (
        .stage_vld     (valid_q),
        .stage_is_load (ctrl_q[MEM_READ_BIT]),
        .stage_dst     (dst_q),
        .in_vld        (valid_in),
        .in_src        (src_in),
        .hazard        (hazard)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        src_d   = src_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush_in || (!stall_in && hazard)) begin
            ctrl_d  = '0;
            dst_d   = '0;
            src_d   = '0;
            addr_d  = '0;
            valid_d = 1'b0;
            if (!flush_in && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!stall_in) begin
            // Control of an empty slot is squashed so it cannot trigger anything downstream.
            ctrl_d  = valid_in ? ctrl_in : '0;
            dst_d   = dst_in;
            src_d   = src_in;
            addr_d  = addr_in;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hazard_stall_out = hazard & ~flush_in & ~stall_in & reset;
    assign ctrl_out         = ctrl_q;
    assign dst_out          = dst_q;
    assign src_out          = src_q;
    assign addr_out         = addr_q;
    assign valid_out        = valid_q;
    assign bubble_count_out = cnt_q;
endmodule

// File: tb/tb_de_stage_register.sv
// Directed bench for de_stage_register: stimulus pushes hand-computed expectations, a monitor pops and compares.
// A second instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_de_stage_register;
    import de_pkg::*;

    logic        clk;
    logic        reset;
    logic [13:0] ctrl_in;
    logic [2:0]  dst_in;
    logic [7:0]  src_in;
    logic [15:0] addr_in;
    logic        valid_in, stall_in, flush_in;
    logic [13:0] ctrl_out, ctrl_out2;
    logic [2:0]  dst_out, dst_out2;
    logic [7:0]  src_out, src_out2;
    logic [15:0] addr_out, addr_out2;
    logic        valid_out, valid_out2, hs_out, hs_out2;
    logic [15:0] cnt_out;
    logic [1:0]  cnt_out2;

    de_stage_register dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .dst_in(dst_in), .src_in(src_in),
        .addr_in(addr_in), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
        .ctrl_out(ctrl_out), .dst_out(dst_out), .src_out(src_out), .addr_out(addr_out),
        .valid_out(valid_out), .hazard_stall_out(hs_out), .bubble_count_out(cnt_out)
    );

    de_stage_register #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .dst_in(dst_in), .src_in(src_in),
        .addr_in(addr_in), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
        .ctrl_out(ctrl_out2), .dst_out(dst_out2), .src_out(src_out2), .addr_out(addr_out2),
        .valid_out(valid_out2), .hazard_stall_out(hs_out2), .bubble_count_out(cnt_out2)
    );

    typedef struct {
        string       name;
        logic        hs;
        de_payload_t out;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    function automatic de_payload_t mk(input logic [13:0] c, input logic [2:0] d,
                                       input logic [7:0] s, input logic [15:0] a, input logic v);
        de_payload_t p;
        p.ctrl  = c;
        p.dst   = d;
        p.src   = s;
        p.addr  = a;
        p.valid = v;
        return p;
    endfunction

    // Monitor: combinational hazard output mid-cycle, registered outputs just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb[0];
                chk(e.name, "hazard_stall", 32'(hs_out), 32'(e.hs));
                @(posedge clk);
                #1;
                chk(e.name, "valid", 32'(valid_out), 32'(e.out.valid));
                chk(e.name, "ctrl", 32'(ctrl_out), 32'(e.out.ctrl));
                chk(e.name, "dst", 32'(dst_out), 32'(e.out.dst));
                chk(e.name, "src", 32'(src_out), 32'(e.out.src));
                chk(e.name, "addr", 32'(addr_out), 32'(e.out.addr));
                chk(e.name, "count", 32'(cnt_out), 32'(e.cnt));
                chk(e.name, "count_sat", 32'(cnt_out2), (e.cnt > 16'd3) ? 32'd3 : 32'(e.cnt));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input string nm, input de_payload_t in, input logic rst_n,
                        input logic stl, input logic fl,
                        input logic exp_hs, input de_payload_t exp_out, input logic [15:0] exp_cnt);
        exp_t e;
        @(posedge clk);
        #2;
        reset    = rst_n;
        ctrl_in  = in.ctrl;
        dst_in   = in.dst;
        src_in   = in.src;
        addr_in  = in.addr;
        valid_in = in.valid;
        stall_in = stl;
        flush_in = fl;
        e.name = nm;
        e.hs   = exp_hs;
        e.out  = exp_out;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    initial begin
        de_payload_t z, p1, ld, ua, ub, uc, uc_out;
        z      = mk(14'h0, 3'd0, 8'h00, 16'h0, 1'b0);
        p1     = mk(14'h0A5, 3'd3, 8'h21, 16'h1234, 1'b1);
        ld     = mk(14'h001, 3'd5, 8'h00, 16'h0BEE, 1'b1);
        ua     = mk(14'h010, 3'd1, 8'h05, 16'h4444, 1'b1);
        ub     = mk(14'h022, 3'd2, 8'h0D, 16'h5555, 1'b1);
        uc     = mk(14'h3FF, 3'd7, 8'h55, 16'hFFFF, 1'b0);
        uc_out = mk(14'h000, 3'd7, 8'h55, 16'hFFFF, 1'b0);

        reset = 1'b0; ctrl_in = p1.ctrl; dst_in = p1.dst; src_in = p1.src;
        addr_in = p1.addr; valid_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;

        step("reset0",      p1, 1'b0, 1'b0, 1'b0, 1'b0, z,  16'd0);
        step("reset1",      p1, 1'b0, 1'b0, 1'b0, 1'b0, z,  16'd0);
        step("pass",        p1, 1'b1, 1'b0, 1'b0, 1'b0, p1, 16'd0);
        step("load",        ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd0);
        step("loaduse",     ua, 1'b1, 1'b0, 1'b0, 1'b1, z,  16'd1);
        step("after_bub",   ua, 1'b1, 1'b0, 1'b0, 1'b0, ua, 16'd1);
        step("load2",       ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd1);
        step("upper_bit",   ub, 1'b1, 1'b0, 1'b0, 1'b0, ub, 16'd1);
        step("load3",       ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd1);
        step("invalid_in",  uc, 1'b1, 1'b0, 1'b0, 1'b0, uc_out, 16'd1);
        step("load4",       ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd1);
        step("flush_haz",   ua, 1'b1, 1'b0, 1'b1, 1'b0, z,  16'd1);
        step("load5",       ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd1);
        step("stall_haz",   ua, 1'b1, 1'b1, 1'b0, 1'b0, ld, 16'd1);
        step("haz_resume",  ua, 1'b1, 1'b0, 1'b0, 1'b1, z,  16'd2);
        step("capture",     ua, 1'b1, 1'b0, 1'b0, 1'b0, ua, 16'd2);
        step("load6",       ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'd2);
        step("reset_haz",   ua, 1'b0, 1'b0, 1'b0, 1'b0, z,  16'd0);
        for (int k = 1; k <= 5; k++) begin
            step("sat_load", ld, 1'b1, 1'b0, 1'b0, 1'b0, ld, 16'(k - 1));
            step("sat_haz",  ua, 1'b1, 1'b0, 1'b0, 1'b1, z,  16'(k));
        end

        repeat (4) @(posedge clk);
        #3;
        chk("drain", "pending", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
